serial_adder: RTL and testbench

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using a registered carry between digits. It is the sequential successor to the team's 1-bit full adder. It trades latency for area and adds a start/busy/done handshake, so a controller can issue back-to-back additions. Results also carry a signed-overflow flag, which the single-bit adder never had.

---
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that produces a + b + cin over WIDTH/DIGIT
// compute cycles. A DIGIT-bit ripple of full adders and a registered carry
// handle each step, and a start/busy/done handshake allows back-to-back
// additions.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Number of compute cycles, and a counter width that stays legal when N=1.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [WIDTH-1:0] a_d, b_d, s_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, cout_q, ovf_q;

  // Ripple carry chain for one digit. rc[0] is the carry into the digit and
  // rc[DIGIT] is the carry out of it.
  logic [DIGIT:0]   rc;
  logic [DIGIT-1:0] sum_digit;
  logic             last_digit;

  assign rc[0] = carry_q;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign sum_digit[gi] = a_q[gi] ^ b_q[gi] ^ rc[gi];
      assign rc[gi+1]      = (a_q[gi] & b_q[gi]) | (rc[gi] & (a_q[gi] ^ b_q[gi]));
    end
  endgenerate

  assign last_digit = (cnt_q == CW'(N - 1));

  // Next values of the operand and sum shift registers. Each new digit is
  // inserted at the MSB end, so it arrives at its final position after N steps.
  always_comb begin
    a_d = a_q >> DIGIT;
    b_d = b_q >> DIGIT;
    s_d = s_q >> DIGIT;
    s_d[WIDTH-1 -: DIGIT] = sum_digit;
  end

  // Control FSM together with the datapath registers and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          s_q     <= s_d;
          carry_q <= rc[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_digit) begin
            // rc[DIGIT-1] is the carry into bit WIDTH-1 on the top digit.
            cout_q  <= rc[DIGIT];
            ovf_q   <= rc[DIGIT-1] ^ rc[DIGIT];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder with three configurations:
// WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4.
module tb_serial_adder;

  logic clk;
  logic rst;

  int checks;
  int failures;

  // WIDTH=1, DIGIT=1
  logic       w1_start, w1_a, w1_b, w1_cin;
  logic       w1_busy, w1_done, w1_s, w1_cout, w1_ovf;
  // WIDTH=8, DIGIT=1
  logic       w8_start, w8_cin;
  logic [7:0] w8_a, w8_b, w8_s;
  logic       w8_busy, w8_done, w8_cout, w8_ovf;
  // WIDTH=8, DIGIT=4
  logic       d4_start, d4_cin;
  logic [7:0] d4_a, d4_b, d4_s;
  logic       d4_busy, d4_done, d4_cout, d4_ovf;

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .start(w1_start), .a(w1_a), .b(w1_b), .cin(w1_cin),
    .busy(w1_busy), .done(w1_done), .s(w1_s), .cout(w1_cout), .ovf(w1_ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clk(clk), .rst(rst), .start(w8_start), .a(w8_a), .b(w8_b), .cin(w8_cin),
    .busy(w8_busy), .done(w8_done), .s(w8_s), .cout(w8_cout), .ovf(w8_ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(d4_start), .a(d4_a), .b(d4_b), .cin(d4_cin),
    .busy(d4_busy), .done(d4_done), .s(d4_s), .cout(d4_cout), .ovf(d4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one WIDTH=8/DIGIT=1 operation from a falling edge and return the
  // number of falling edges until done is seen (bounded).
  task automatic run_w8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, output int lat);
    w8_a = ta; w8_b = tb_v; w8_cin = tc; w8_start = 1'b1;
    @(negedge clk);
    lat = 1;
    w8_start = 1'b0;
    while (!w8_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_d4(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, output int lat);
    d4_a = ta; d4_b = tb_v; d4_cin = tc; d4_start = 1'b1;
    @(negedge clk);
    lat = 1;
    d4_start = 1'b0;
    while (!d4_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({w8_busy, w8_done, w8_s, w8_cout, w8_ovf} !== 12'h000) begin
      failures++;
      $display("FAIL reset_w8 got busy=%b done=%b s=%h cout=%b ovf=%b expected all zero",
               w8_busy, w8_done, w8_s, w8_cout, w8_ovf);
    end
    checks++;
    if ({d4_busy, d4_done, d4_s, d4_cout, d4_ovf} !== 12'h000) begin
      failures++;
      $display("FAIL reset_d4 got busy=%b done=%b s=%h cout=%b ovf=%b expected all zero",
               d4_busy, d4_done, d4_s, d4_cout, d4_ovf);
    end
    checks++;
    if ({w1_busy, w1_done, w1_s, w1_cout, w1_ovf} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_w1 got busy=%b done=%b s=%b cout=%b ovf=%b expected all zero",
               w1_busy, w1_done, w1_s, w1_cout, w1_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  // Full truth table of the 1-bit case: {cout,s} for each (a,b,cin).
  task automatic test_width1;
    logic [1:0] exp_tab [8];
    logic [2:0] v;
    int lat;
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      w1_a = v[2]; w1_b = v[1]; w1_cin = v[0]; w1_start = 1'b1;
      @(negedge clk);
      w1_start = 1'b0;
      checks++;
      if (w1_busy !== 1'b1) begin
        failures++;
        $display("FAIL w1_busy[%0d] got %b expected 1", i, w1_busy);
      end
      lat = 1;
      while (!w1_done && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL w1_latency[%0d] got %0d expected 2", i, lat);
      end
      checks++;
      if ({w1_cout, w1_s} !== exp_tab[i]) begin
        failures++;
        $display("FAIL w1_sum[%0d] got %b expected %b", i, {w1_cout, w1_s}, exp_tab[i]);
      end
      $display("w1 a=%b b=%b cin=%b -> cout,s=%b%b", v[2], v[1], v[0], w1_cout, w1_s);
      @(negedge clk);
    end
  endtask

  // Directed WIDTH=8/DIGIT=1 additions including carry and overflow corners.
  task automatic test_w8_vectors;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic       eo [4];
    int lat;
    va = '{8'hFF, 8'h7F, 8'h80, 8'h3C};
    vb = '{8'h01, 8'h01, 8'h80, 8'h41};
    vc = '{1'b0,  1'b0,  1'b0,  1'b1};
    es = '{8'h00, 8'h80, 8'h00, 8'h7E};
    ec = '{1'b1,  1'b0,  1'b1,  1'b0};
    eo = '{1'b0,  1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 4; i++) begin
      run_w8(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 9) begin
        failures++;
        $display("FAIL w8_latency[%0d] got %0d expected 9", i, lat);
      end
      checks++;
      if ({w8_cout, w8_s, w8_ovf} !== {ec[i], es[i], eo[i]}) begin
        failures++;
        $display("FAIL w8_result[%0d] got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                 i, w8_s, w8_cout, w8_ovf, es[i], ec[i], eo[i]);
      end
      $display("w8 a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d",
               va[i], vb[i], vc[i], w8_s, w8_cout, w8_ovf, lat);
      @(negedge clk);
      checks++;
      if (w8_done !== 1'b0 || w8_s !== es[i]) begin
        failures++;
        $display("FAIL w8_after_done[%0d] got done=%b s=%h expected done=0 s=%h",
                 i, w8_done, w8_s, es[i]);
      end
    end
  endtask

  // DIGIT=4: second operation started in the DONE cycle of the first.
  task automatic test_back_to_back;
    int lat;
    run_d4(8'hA5, 8'h5A, 1'b1, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL d4_latency1 got %0d expected 3", lat);
    end
    checks++;
    if ({d4_cout, d4_s, d4_ovf} !== {1'b1, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL d4_result1 got s=%h cout=%b ovf=%b expected s=00 cout=1 ovf=0",
               d4_s, d4_cout, d4_ovf);
    end
    $display("d4 a=a5 b=5a cin=1 -> s=%h cout=%b ovf=%b lat=%0d", d4_s, d4_cout, d4_ovf, lat);
    run_d4(8'h12, 8'h34, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL d4_latency2 got %0d expected 3", lat);
    end
    checks++;
    if ({d4_cout, d4_s, d4_ovf} !== {1'b0, 8'h46, 1'b0}) begin
      failures++;
      $display("FAIL d4_result2 got s=%h cout=%b ovf=%b expected s=46 cout=0 ovf=0",
               d4_s, d4_cout, d4_ovf);
    end
    $display("d4 a=12 b=34 cin=0 -> s=%h cout=%b ovf=%b lat=%0d", d4_s, d4_cout, d4_ovf, lat);
    @(negedge clk);
  endtask

  // A start pulse three cycles into RUN must not disturb the operation.
  task automatic test_start_ignored;
    int ndone;
    int first_done;
    logic [7:0] s_at_done;
    ndone = 0; first_done = 0; s_at_done = 8'h00;
    w8_a = 8'h10; w8_b = 8'h20; w8_cin = 1'b0; w8_start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) w8_start = 1'b0;
      if (i == 3) begin
        w8_a = 8'hFF; w8_b = 8'hFF; w8_cin = 1'b1; w8_start = 1'b1;
      end
      if (i == 4) w8_start = 1'b0;
      if (w8_done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = i;
          s_at_done = w8_s;
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got %0d expected 1", ndone);
    end
    checks++;
    if (first_done !== 9) begin
      failures++;
      $display("FAIL ignore_latency got %0d expected 9", first_done);
    end
    checks++;
    if (s_at_done !== 8'h30) begin
      failures++;
      $display("FAIL ignore_result got s=%h expected 30", s_at_done);
    end
    $display("ignore: done_pulses=%0d at=%0d s=%h", ndone, first_done, s_at_done);
  endtask

  // Reset four cycles into RUN aborts without done; a new add then works.
  task automatic test_reset_mid_run;
    int ndone;
    int lat;
    w8_a = 8'h55; w8_b = 8'h11; w8_cin = 1'b0; w8_start = 1'b1;
    @(negedge clk);
    w8_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({w8_busy, w8_done, w8_s, w8_cout, w8_ovf} !== 12'h000) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b done=%b s=%h cout=%b ovf=%b expected all zero",
               w8_busy, w8_done, w8_s, w8_cout, w8_ovf);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (w8_done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midrun_no_done got %0d pulses expected 0", ndone);
    end
    run_w8(8'h03, 8'h04, 1'b0, lat);
    checks++;
    if (lat !== 9 || w8_s !== 8'h07 || w8_cout !== 1'b0) begin
      failures++;
      $display("FAIL midrun_restart got lat=%0d s=%h cout=%b expected lat=9 s=07 cout=0",
               lat, w8_s, w8_cout);
    end
    $display("reset mid-run: restart s=%h lat=%0d", w8_s, lat);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    w1_start = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
    w8_start = 1'b0; w8_a = 8'h00; w8_b = 8'h00; w8_cin = 1'b0;
    d4_start = 1'b0; d4_a = 8'h00; d4_b = 8'h00; d4_cin = 1'b0;
    @(negedge clk);
    test_reset;
    test_width1;
    test_w8_vectors;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
